wb_retire: RTL and testbench

- Writeback/retire end of the register scoreboard protocol.
- Accepts completed instructions from the memory stage over a valid/ready handshake and buffers them in a small in-order FIFO.
- Retires at most one instruction per cycle, driving the register-file write port and the scoreboard-clear strobe (validout, rf_wen_reg_wb, rf_waddr, wdata) back to the decode stage.
- Keeps a 64-bit retired-instruction counter.

---
 rtl/wb_retire.sv | 124 ++++++++++++
 tb/tb_wb_retire.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_retire.sv
// Writeback/retire stage: in-order FIFO of completed instructions, one retirement per cycle.
// Optional commit trace ports are enabled by defining WB_COMMIT_TRACE_EN.
module wb_retire #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_rf_wen,
    input  logic [4:0]       in_rd,
    input  logic [63:0]      in_data,
    input  logic [63:0]      in_pc,
`ifdef WB_COMMIT_TRACE_EN
    input  logic [31:0]      in_inst,
    output logic [31:0]      retire_inst,
    output logic             commit_valid,
`endif
    input  logic             wb_hold,
    output logic             validout,
    output logic             rf_wen_reg_wb,
    output logic [4:0]       rf_waddr,
    output logic [63:0]      wdata,
    output logic [63:0]      retire_pc,
    output logic [63:0]      instret,
    output logic [PTR_W:0]   fifo_cnt
);

    logic             wen_mem  [DEPTH];
    logic [4:0]       rd_mem   [DEPTH];
    logic [63:0]      data_mem [DEPTH];
    logic [63:0]      pc_mem   [DEPTH];
`ifdef WB_COMMIT_TRACE_EN
    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      inst_q;
`endif

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             full, push, pop;
    logic             valid_q, wen_q;
    logic [4:0]       waddr_q;
    logic [63:0]      wdata_q, pc_q, instret_q;

    // A full FIFO refuses pushes even if a pop frees a slot this cycle.
    always_comb begin
        full  = (cnt_q == (PTR_W+1)'(DEPTH));
        push  = in_valid & ~full;
        pop   = (cnt_q != '0) & ~wb_hold;
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + (PTR_W+1)'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - (PTR_W+1)'(1);
        end
    end

    // Storage is unreset; entries are only ever read once written.
    always_ff @(posedge clk) begin
        if (push) begin
            wen_mem[wr_ptr_q]  <= in_rf_wen;
            rd_mem[wr_ptr_q]   <= in_rd;
            data_mem[wr_ptr_q] <= in_data;
            pc_mem[wr_ptr_q]   <= in_pc;
`ifdef WB_COMMIT_TRACE_EN
            inst_mem[wr_ptr_q] <= in_inst;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            pc_q      <= '0;
            instret_q <= '0;
`ifdef WB_COMMIT_TRACE_EN
            inst_q    <= '0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= pop;
            wen_q   <= pop ? wen_mem[rd_ptr_q] : 1'b0;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                waddr_q  <= rd_mem[rd_ptr_q];
                // x0 still clears its scoreboard bit but always writes zero.
                wdata_q  <= (rd_mem[rd_ptr_q] == 5'd0) ? 64'd0 : data_mem[rd_ptr_q];
                pc_q     <= pc_mem[rd_ptr_q];
`ifdef WB_COMMIT_TRACE_EN
                inst_q   <= inst_mem[rd_ptr_q];
`endif
            end
            if (valid_q) begin
                instret_q <= instret_q + 64'd1;
            end
        end
    end

    always_comb begin
        in_ready      = ~full;
        validout      = valid_q;
        rf_wen_reg_wb = wen_q;
        rf_waddr      = waddr_q;
        wdata         = wdata_q;
        retire_pc     = pc_q;
        instret       = instret_q;
        fifo_cnt      = cnt_q;
`ifdef WB_COMMIT_TRACE_EN
        retire_inst   = inst_q;
        commit_valid  = valid_q;
`endif
    end

endmodule

// File: tb/tb_wb_retire.sv
// Self-checking bench for wb_retire: directed scenarios plus random traffic against a queue model.
module tb_wb_retire;

    localparam int unsigned DEPTH = 4;

    logic        clk, rst, in_valid, in_ready, in_rf_wen, wb_hold;
    logic [4:0]  in_rd;
    logic [63:0] in_data, in_pc;
    logic        validout, rf_wen_reg_wb;
    logic [4:0]  rf_waddr;
    logic [63:0] wdata, retire_pc, instret;
    logic [2:0]  fifo_cnt;
    logic [31:0] in_inst;
`ifdef WB_COMMIT_TRACE_EN
    logic [31:0] retire_inst;
    logic        commit_valid;
`endif

    wb_retire #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rf_wen     (in_rf_wen),
        .in_rd         (in_rd),
        .in_data       (in_data),
        .in_pc         (in_pc),
`ifdef WB_COMMIT_TRACE_EN
        .in_inst       (in_inst),
        .retire_inst   (retire_inst),
        .commit_valid  (commit_valid),
`endif
        .wb_hold       (wb_hold),
        .validout      (validout),
        .rf_wen_reg_wb (rf_wen_reg_wb),
        .rf_waddr      (rf_waddr),
        .wdata         (wdata),
        .retire_pc     (retire_pc),
        .instret       (instret),
        .fifo_cnt      (fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    logic        exp_valid, exp_wen;
    logic [4:0]  exp_waddr;
    logic [63:0] exp_wdata, exp_pc, exp_instret;
    logic [31:0] exp_inst;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model across the edge, then compare all outputs.
    task automatic cycle(input logic v, input logic w, input logic [4:0] rd,
                         input logic [63:0] d, input logic [63:0] pc, input logic [31:0] inst,
                         input logic hold, input logic r, output logic acc);
        ent_t h;
        logic do_push;
        in_valid  = v;
        in_rf_wen = w;
        in_rd     = rd;
        in_data   = d;
        in_pc     = pc;
        in_inst   = inst;
        wb_hold   = hold;
        rst       = r;
        @(posedge clk);
        acc = 1'b0;
        if (r) begin
            q.delete();
            exp_valid = 0; exp_wen = 0; exp_waddr = 0; exp_wdata = 0;
            exp_pc = 0; exp_inst = 0; exp_instret = 0;
        end else begin
            do_push = v && (q.size() < DEPTH);
            exp_instret = exp_instret + (exp_valid ? 64'd1 : 64'd0);
            if (q.size() != 0 && !hold) begin
                h = q.pop_front();
                exp_valid = 1; exp_wen = h.w; exp_waddr = h.rd;
                exp_wdata = (h.rd == 0) ? 64'd0 : h.data;
                exp_pc = h.pc; exp_inst = h.inst;
            end else begin
                exp_valid = 0; exp_wen = 0;
            end
            if (do_push) begin
                q.push_back('{w: w, rd: rd, data: d, pc: pc, inst: inst});
                acc = 1'b1;
            end
        end
        #1;
        chk("validout", {63'd0, validout}, {63'd0, exp_valid});
        chk("rf_wen_reg_wb", {63'd0, rf_wen_reg_wb}, {63'd0, exp_wen});
        chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, exp_waddr});
        chk("wdata", wdata, exp_wdata);
        chk("retire_pc", retire_pc, exp_pc);
        chk("instret", instret, exp_instret);
        chk("fifo_cnt", {61'd0, fifo_cnt}, 64'(q.size()));
        chk("in_ready", {63'd0, in_ready}, {63'd0, (q.size() != DEPTH)});
`ifdef WB_COMMIT_TRACE_EN
        chk("retire_inst", {32'd0, retire_inst}, {32'd0, exp_inst});
        chk("commit_valid", {63'd0, commit_valid}, {63'd0, exp_valid});
`endif
    endtask

    task automatic idle(input logic hold);
        logic a;
        cycle(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0, hold, 1'b0, a);
    endtask

    initial begin
        logic        acc;
        logic [63:0] base;
        logic [4:0]  rd;
        exp_valid = 0; exp_wen = 0; exp_waddr = 0; exp_wdata = 0;
        exp_pc = 0; exp_inst = 0; exp_instret = 0;
        in_valid = 0; in_rf_wen = 0; in_rd = 0; in_data = 0; in_pc = 0; in_inst = 0;
        wb_hold = 0; rst = 1;

        cycle(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0, 1'b0, 1'b1, acc);
        cycle(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0, 1'b0, 1'b1, acc);

        // Single push, one-cycle latency, instret follows a cycle later.
        cycle(1'b1, 1'b1, 5'd5, 64'h1234, 64'h8000_0000, 32'h13, 1'b0, 1'b0, acc);
        idle(1'b0);
        chk("t1_validout", {63'd0, validout}, 64'd1);
        chk("t1_waddr", {59'd0, rf_waddr}, 64'd5);
        chk("t1_wdata", wdata, 64'h1234);
        chk("t1_pc", retire_pc, 64'h8000_0000);
        idle(1'b0);
        chk("t1_instret", instret, 64'd1);

        // x0 destination: write enable kept, data forced to zero.
        cycle(1'b1, 1'b1, 5'd0, 64'hDEAD, 64'h8000_0004, 32'h93, 1'b0, 1'b0, acc);
        idle(1'b0);
        chk("t2_wen", {63'd0, rf_wen_reg_wb}, 64'd1);
        chk("t2_wdata_x0", wdata, 64'd0);
        idle(1'b0);

        // Hold: fill to DEPTH, fifth refused, then drain in order.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b1, 5'(i + 1), 64'(100 + i), 64'(32'h9000_0000 + 4 * i), 32'(i),
                  1'b1, 1'b0, acc);
        chk("t3_full_cnt", {61'd0, fifo_cnt}, 64'd4);
        chk("t3_not_ready", {63'd0, in_ready}, 64'd0);
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++)
            cycle(1'b1, 1'b1, 5'd5, 64'd104, 64'h9000_0010, 32'd4, 1'b0, 1'b0, acc);
        chk("t3_fifth_accepted", {63'd0, acc}, 64'd1);
        for (int i = 0; i < 6; i++) idle(1'b0);

        // Streaming: one push per cycle never backs up.
        base = instret;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 5'(i + 1), {$urandom, $urandom}, 64'(i * 4), $urandom,
                  1'b0, 1'b0, acc);
            chk("t4_ready", {63'd0, in_ready}, 64'd1);
            chk("t4_cnt_le1", {63'd0, (fifo_cnt <= 3'd1)}, 64'd1);
        end
        idle(1'b0);
        idle(1'b0);
        chk("t4_instret_delta", instret - base, 64'd20);

        // Store-like entry: retires without a register write.
        cycle(1'b1, 1'b0, 5'd7, 64'h55, 64'hA000, 32'h23, 1'b0, 1'b0, acc);
        idle(1'b0);
        chk("t5_valid", {63'd0, validout}, 64'd1);
        chk("t5_wen", {63'd0, rf_wen_reg_wb}, 64'd0);

        // Reset with three buffered entries: nothing stale may retire afterwards.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b1, 5'(9 + i), 64'(i), 64'(i), 32'(i), 1'b1, 1'b0, acc);
        chk("t6_cnt3", {61'd0, fifo_cnt}, 64'd3);
        cycle(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0, 1'b0, 1'b1, acc);
        chk("t6_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 4; i++) idle(1'b0);

        // Random traffic with holds and rare resets.
        for (int i = 0; i < 400; i++) begin
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), rd, {$urandom, $urandom},
                  {$urandom, $urandom}, $urandom, ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 99) == 0), acc);
        end
        for (int i = 0; i < 6; i++) idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
